ntt_pass_sequencer: RTL and testbench

Parametrised pass sequencer for the unified Kyber/Dilithium NTT/INTT datapath.
- Runs the full multi-pass schedule from a single start/done handshake and issues bank read strobes and pass-local read indices.
- Carries each read index through a programmable write-back delay line so results are written back to the index they were read from.
- Generalises the fixed 9/12-cycle gated-clock address shifters to a run-time latency per pass on the free-running clock. Sits between the control interface and the address-mapping/bank logic.

---
 rtl/ntt_pkg.sv | 33 +++
 rtl/ntt_wb_delay.sv | 51 +++++
 rtl/ntt_pass_sequencer.sv | 123 ++++++++++++
 tb/tb_ntt_pass_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the Kyber/Dilithium NTT pass sequencer: mode codes,
// sequencer FSM states and the per-mode radix schedule.
package ntt_pkg;

   localparam logic KD_KYBER     = 1'b0;
   localparam logic KD_DILITHIUM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } seq_state_t;

   localparam logic [2:0] PASSES_KYBER     = 3'd4;
   localparam logic [2:0] PASSES_DILITHIUM = 3'd4;

   // Bit p set means pass p runs radix-4 butterflies.
   localparam logic [3:0] R4_KYBER_NTT  = 4'b0111;
   localparam logic [3:0] R4_KYBER_INTT = 4'b1110;
   localparam logic [3:0] R4_DILITHIUM  = 4'b1111;

   function automatic logic [2:0] num_passes(input logic kd);
      return (kd == KD_DILITHIUM) ? PASSES_DILITHIUM : PASSES_KYBER;
   endfunction

   function automatic logic pass_is_r4(input logic kd, input logic inv, input logic [2:0] p);
      logic [3:0] sched;
      sched = (kd == KD_KYBER) ? (inv ? R4_KYBER_INTT : R4_KYBER_NTT) : R4_DILITHIUM;
      return p[2] ? 1'b0 : sched[p[1:0]];
   endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Free-running write-back delay line with a run-time output tap (1..MAX_LAT cycles).
// No backpressure: shifts every cycle; empty means nothing remains to emit after this cycle.
module ntt_wb_delay
   import ntt_pkg::*;
#(
   parameter  int W       = 9,
   parameter  int MAX_LAT = 16,
   localparam int LAT_W   = $clog2(MAX_LAT + 1),
   localparam int TAP_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [W-1:0]     in_dat,
   input  logic [LAT_W-1:0] lat,
   output logic             out_vld,
   output logic [W-1:0]     out_dat,
   output logic             empty
);

   logic [MAX_LAT-1:0] vld;
   logic [W-1:0]       dat [MAX_LAT];
   logic [TAP_W-1:0]   tap;

   assign tap     = TAP_W'(lat - LAT_W'(1));
   assign out_vld = vld[tap];
   assign out_dat = dat[tap];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < MAX_LAT; i++) dat[i] <= '0;
      end else begin
         vld[0] <= in_vld;
         dat[0] <= in_dat;
         for (int i = 1; i < MAX_LAT; i++) begin
            // entries shifted past the tap were already written back; drop them
            vld[i] <= vld[i-1] && (lat > LAT_W'(i));
            dat[i] <= dat[i-1];
         end
      end
   end

   always_comb begin
      empty = !in_vld;
      for (int i = 0; i < MAX_LAT - 1; i++) begin
         if (vld[i] && (lat > LAT_W'(i + 1))) empty = 1'b0;
      end
   end

endmodule

// File: rtl/ntt_pass_sequencer.sv
// Multi-pass NTT/INTT read/write-back sequencer; writes trail reads by the pass latency L.
// No backpressure: one read per cycle within a pass; start is only accepted in IDLE.
module ntt_pass_sequencer
   import ntt_pkg::*;
#(
   parameter  int N_COEF    = 256,
   parameter  int NUM_BANKS = 4,
   parameter  int IDX_W     = $clog2(N_COEF / NUM_BANKS),
   parameter  int MAX_LAT   = 16,
   localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kd_mode,
   input  logic             inv,
   input  logic [LAT_W-1:0] lat_r4,
   input  logic [LAT_W-1:0] lat_r2,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_idx,
   output logic [2:0]       pass,
   output logic             radix4,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [2:0]       wr_pass
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_COEF / NUM_BANKS - 1);
   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
   localparam int               DLY_W     = 3 + IDX_W;

   seq_state_t       state, state_nxt;
   logic             kd_q, inv_q;
   logic [LAT_W-1:0] lat4_q, lat2_q;
   logic [IDX_W-1:0] rd_idx_q;
   logic [2:0]       pass_q;
   logic             cur_r4, last_pass;
   logic [LAT_W-1:0] cur_lat;
   logic             dly_vld, dly_empty;
   logic [DLY_W-1:0] dly_dat;

   function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
      if (l == '0) return LAT_W'(1);
      if (l > MAX_LAT_V) return MAX_LAT_V;
      return l;
   endfunction

   assign cur_r4    = pass_is_r4(kd_q, inv_q, pass_q);
   assign cur_lat   = cur_r4 ? lat4_q : lat2_q;
   assign last_pass = (pass_q == num_passes(kd_q) - 3'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_READ;
         ST_READ:  if (rd_idx_q == LAST_IDX) state_nxt = ST_DRAIN;
         // leave as the last in-flight entry reaches the tap, so the next read follows its write
         ST_DRAIN: if (dly_empty) state_nxt = last_pass ? ST_DONE : ST_READ;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == ST_READ) || (state == ST_DRAIN);
      done   = (state == ST_DONE);
      rd_en  = (state == ST_READ);
      radix4 = busy && cur_r4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kd_q     <= 1'b0;
         inv_q    <= 1'b0;
         lat4_q   <= LAT_W'(1);
         lat2_q   <= LAT_W'(1);
         rd_idx_q <= '0;
         pass_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               kd_q     <= kd_mode;
               inv_q    <= inv;
               lat4_q   <= clamp_lat(lat_r4);
               lat2_q   <= clamp_lat(lat_r2);
               rd_idx_q <= '0;
               pass_q   <= '0;
            end
            ST_READ:  rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
            ST_DRAIN: if (dly_empty && !last_pass) pass_q <= pass_q + 3'd1;
            default:  ;
         endcase
      end
   end

   ntt_wb_delay #(
      .W       (DLY_W),
      .MAX_LAT (MAX_LAT)
   ) u_wb_delay (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_en),
      .in_dat  ({pass_q, rd_idx_q}),
      .lat     (cur_lat),
      .out_vld (dly_vld),
      .out_dat (dly_dat),
      .empty   (dly_empty)
   );

   assign rd_idx  = rd_idx_q;
   assign pass    = pass_q;
   assign wr_en   = dly_vld;
   assign wr_idx  = dly_vld ? dly_dat[IDX_W-1:0] : '0;
   assign wr_pass = dly_vld ? dly_dat[DLY_W-1:IDX_W] : '0;

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Bench for ntt_pass_sequencer: table of transforms, per-cycle control model and a
// write-back scoreboard filled when each transform is started.
module tb_ntt_pass_sequencer;

   localparam int CPP = 64;

   logic       clk = 1'b0;
   logic       rst, start, kd_mode, inv;
   logic [4:0] lat_r4, lat_r2;
   logic       busy, done, rd_en, radix4, wr_en;
   logic [5:0] rd_idx, wr_idx;
   logic [2:0] pass, wr_pass;

   always #5 clk = ~clk;

   ntt_pass_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .kd_mode(kd_mode), .inv(inv),
      .lat_r4(lat_r4), .lat_r2(lat_r2), .busy(busy), .done(done), .rd_en(rd_en),
      .rd_idx(rd_idx), .pass(pass), .radix4(radix4), .wr_en(wr_en),
      .wr_idx(wr_idx), .wr_pass(wr_pass)
   );

   typedef struct {
      logic kd;
      logic inv;
      int   l4;
      int   l2;
      int   exp_done;   // hand-computed: sum(CPP + L_p) + 1
      int   poke;       // cycle of a conflicting start pulse, 0 = none
      int   rst_at;     // cycle at which rst is raised, 0 = none
   } vec_t;

   typedef struct {
      int cyc;
      int idx;
      int pss;
   } wr_t;

   vec_t vecs[11];
   wr_t  sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int eff_lat(input int l);
      if (l == 0) return 1;
      if (l > 16) return 16;
      return l;
   endfunction

   function automatic logic tb_r4(input logic kd, input logic iv, input int p);
      if (kd) return 1'b1;
      if (!iv) return p != 3;
      return p != 0;
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({busy, done, rd_en, rd_idx, pass, radix4, wr_en, wr_idx, wr_pass});
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int ps[4];
      int pl[4];
      int t, done_c, done_seen, wr_cnt, lim, p, k;
      logic e_busy, e_done, e_rd, e_r4;
      logic [12:0] exp_v, mask, act_v;
      wr_t e;

      sb.delete();
      t = 1;
      for (int q = 0; q < 4; q++) begin
         pl[q] = tb_r4(v.kd, v.inv, q) ? eff_lat(v.l4) : eff_lat(v.l2);
         ps[q] = t;
         for (int j = 0; j < CPP; j++) begin
            e.cyc = t + j + pl[q];
            e.idx = j;
            e.pss = q;
            sb.push_back(e);
         end
         t += CPP + pl[q];
      end
      done_c    = t;
      done_seen = -1;
      wr_cnt    = 0;
      lim       = (v.rst_at > 0) ? v.rst_at + 30 : done_c + 8;

      @(negedge clk);
      start = 1'b1; kd_mode = v.kd; inv = v.inv;
      lat_r4 = 5'(v.l4); lat_r2 = 5'(v.l2);
      @(posedge clk);
      #1;
      // inputs wander while busy; none of this may matter
      start = 1'b0; kd_mode = ~v.kd; inv = ~v.inv;
      lat_r4 = 5'($urandom_range(31)); lat_r2 = 5'($urandom_range(31));

      for (int c = 1; c <= lim; c++) begin
         @(negedge clk);
         if (v.rst_at > 0 && c > v.rst_at) begin
            check($sformatf("%s outputs after rst c%0d", tag, c), all_outputs(), 64'(0));
            if (c == v.rst_at + 1) rst = 1'b0;
         end else begin
            p = 0;
            for (int q = 1; q < 4; q++) if (c >= ps[q]) p = q;
            k = c - ps[p];
            e_busy = (c < done_c);
            e_done = (c == done_c);
            e_rd   = e_busy && (k < CPP);
            e_r4   = e_busy && tb_r4(v.kd, v.inv, p);
            mask   = {3'b111, e_rd ? 6'h3f : 6'h00, e_busy ? 4'hf : 4'h0};
            exp_v  = {e_busy, e_done, e_rd, 6'(k), 3'(p), e_r4};
            act_v  = {busy, done, rd_en, rd_idx, pass, radix4};
            check($sformatf("%s ctl c%0d", tag, c), 64'(act_v & mask), 64'(exp_v & mask));
            if (done && done_seen < 0) done_seen = c;
            if (wr_en) begin
               wr_cnt++;
               if (sb.size() == 0) begin
                  check($sformatf("%s extra wr_en c%0d", tag, c), 64'(wr_en), 64'(0));
               end else begin
                  e = sb.pop_front();
                  check($sformatf("%s wr c%0d {cyc,idx,pass}", tag, c),
                        {32'(c), 16'(wr_idx), 16'(wr_pass)},
                        {32'(e.cyc), 16'(e.idx), 16'(e.pss)});
               end
            end
            if (c == v.rst_at) rst = 1'b1;
         end
         if (c == v.poke) begin
            start = 1'b1; kd_mode = ~v.kd; inv = ~v.inv; lat_r4 = 5'd1; lat_r2 = 5'd1;
         end else begin
            start = 1'b0;
         end
      end

      if (v.rst_at == 0) begin
         check({tag, " done cycle"}, 64'(done_seen), 64'(v.exp_done));
         check({tag, " wr_en count"}, 64'(wr_cnt), 64'(4 * CPP));
         check({tag, " writes left"}, 64'(sb.size()), 64'(0));
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0,  9, 12, 296,   0,   0};  // Kyber NTT
      vecs[1]  = '{1'b1, 1'b0,  9, 12, 293,   0,   0};  // Dilithium NTT
      vecs[2]  = '{1'b0, 1'b1,  9, 12, 296,   0,   0};  // Kyber INTT
      vecs[3]  = '{1'b1, 1'b1,  9, 12, 293,   0,   0};  // Dilithium INTT
      vecs[4]  = '{1'b0, 1'b0,  0, 12, 272,   0,   0};  // r4 latency 0 -> 1
      vecs[5]  = '{1'b0, 1'b0, 31, 12, 317,   0,   0};  // r4 latency 31 -> 16
      vecs[6]  = '{1'b0, 1'b0,  5,  1, 273,   0,   0};
      vecs[7]  = '{1'b0, 1'b0,  9, 12, 296, 100,   0};  // start while busy
      vecs[8]  = '{1'b1, 1'b1, 31,  0, 321, 150,   0};
      vecs[9]  = '{1'b0, 1'b0,  9, 12, 296,   0, 160};  // rst during pass 2
      vecs[10] = '{1'b0, 1'b0,  9, 12, 296,   0,   0};  // fresh run after rst

      rst = 1'b1; start = 1'b0; kd_mode = 1'b0; inv = 1'b0; lat_r4 = '0; lat_r2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs (rst high)", all_outputs(), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("reset outputs (idle)", all_outputs(), 64'(0));

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
